// File: rtl/sha256_round_ctrl_if.sv
// Block/round interface of the SHA-256 round controller.
// master = block source and round datapath side, slave = the controller.
interface sha256_round_ctrl_if #(
  parameter int AW = 6
);
  logic          start;
  logic          blk_valid;
  logic          blk_last;
  logic          blk_ready;
  logic [AW-1:0] k_addr;
  logic          rnd_en;
  logic [AW-1:0] rnd_idx;
  logic          w_sel;
  logic          init_h;
  logic          load_ab;
  logic          upd_h;
  logic          busy;
  logic          digest_valid;

  modport master (
    output start, blk_valid, blk_last,
    input  blk_ready, k_addr, rnd_en, rnd_idx, w_sel,
           init_h, load_ab, upd_h, busy, digest_valid
  );

  modport slave (
    input  start, blk_valid, blk_last,
    output blk_ready, k_addr, rnd_en, rnd_idx, w_sel,
           init_h, load_ab, upd_h, busy, digest_valid
  );
endinterface

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: walks the K[t] ROM address, emits round
// enables aligned to the ROM output, and steps H through init/load/update.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for start
// INIT     | init_h pulse, H <= IV
// WAIT_BLK | blk_ready high, waiting for a message block
// LOAD     | load_ab pulse, a..h <= H, issue counter cleared
// ROUNDS   | k_addr = 0..ROUNDS-1, one address per cycle
// DRAIN    | ROM_LAT cycles for the last K[t] to reach the round engine
// UPDATE   | upd_h pulse, H += a..h
// DONE     | digest_valid pulse
module sha256_round_ctrl #(
  parameter int ROUNDS  = 64,
  parameter int AW      = 6,
  parameter int ROM_LAT = 1
) (
  input logic              clk,
  input logic              reset,
  sha256_round_ctrl_if.slave bus
);

  localparam int            DW       = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(ROUNDS - 1);
  localparam logic [DW-1:0] DRAIN_LD = DW'(ROM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_WAIT_BLK,
    S_LOAD,
    S_ROUNDS,
    S_DRAIN,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] issue_cnt;
  logic [DW-1:0] drain_cnt;
  logic          last_q;
  logic          k_valid;

  // Round-alignment pipe: stage ROM_LAT-1 is what the round engine sees.
  logic [ROM_LAT-1:0] pipe_v;
  logic [AW-1:0]      pipe_idx [ROM_LAT];

  assign k_valid = (state == S_ROUNDS);

  // State register; a low reset aborts whatever is in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (bus.start) state_nxt = S_INIT;
      S_INIT:     state_nxt = S_WAIT_BLK;
      S_WAIT_BLK: if (bus.blk_valid) state_nxt = S_LOAD;
      S_LOAD:     state_nxt = S_ROUNDS;
      S_ROUNDS:   if (issue_cnt == LAST_IDX) state_nxt = S_DRAIN;
      S_DRAIN:    if (drain_cnt == '0) state_nxt = S_UPDATE;
      S_UPDATE:   state_nxt = last_q ? S_DONE : S_WAIT_BLK;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Issue counter (up, stops at ROUNDS-1), drain down-counter, last-block flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      issue_cnt <= '0;
      drain_cnt <= '0;
      last_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          issue_cnt <= '0;
          last_q    <= 1'b0;
        end
        S_WAIT_BLK: begin
          if (bus.blk_valid) last_q <= bus.blk_last;
        end
        S_LOAD: begin
          issue_cnt <= '0;
        end
        S_ROUNDS: begin
          if (issue_cnt != LAST_IDX) issue_cnt <= issue_cnt + 1'b1;
          drain_cnt <= DRAIN_LD;
        end
        S_DRAIN: begin
          if (drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Delay the issued address by ROM_LAT cycles so rnd_en meets valid k_out.
  // Index is zeroed when not valid so rnd_idx reads 0 outside the window.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pipe_v <= '0;
      for (int i = 0; i < ROM_LAT; i++) pipe_idx[i] <= '0;
    end else begin
      pipe_v[0]   <= k_valid;
      pipe_idx[0] <= k_valid ? issue_cnt : '0;
      for (int i = 1; i < ROM_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
    end
  end

  // Output decode; every control pulse is tied to exactly one state.
  always_comb begin
    bus.blk_ready    = 1'b0;
    bus.init_h       = 1'b0;
    bus.load_ab      = 1'b0;
    bus.upd_h        = 1'b0;
    bus.digest_valid = 1'b0;
    bus.busy         = (state != S_IDLE);
    bus.k_addr       = k_valid ? issue_cnt : '0;
    bus.rnd_en       = pipe_v[ROM_LAT-1];
    bus.rnd_idx      = pipe_idx[ROM_LAT-1];
    bus.w_sel        = pipe_v[ROM_LAT-1] && (int'(pipe_idx[ROM_LAT-1]) >= 16);
    case (state)
      S_INIT:     bus.init_h       = 1'b1;
      S_WAIT_BLK: bus.blk_ready    = 1'b1;
      S_LOAD:     bus.load_ab      = 1'b1;
      S_UPDATE:   bus.upd_h        = 1'b1;
      S_DONE:     bus.digest_valid = 1'b1;
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: ROM_LAT=1 instance drives a reference SHA-256
// datapath and a timing scoreboard; a ROM_LAT=2 instance is checked cycle by cycle.
module tb_sha256_round_ctrl;

  localparam int ROUNDS = 64;
  localparam int LAT1   = 1;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_2BLK = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sha256_round_ctrl_if #(.AW(6)) bus1 ();
  sha256_round_ctrl_if #(.AW(6)) bus2 ();

  sha256_round_ctrl #(.ROUNDS(64), .AW(6), .ROM_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  sha256_round_ctrl #(.ROUNDS(64), .AW(6), .ROM_LAT(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_ev(string nm);
    total++;
    bad++;
    $display("FAIL %s: got unexpected event expected none (cyc %0d)", nm, cyc);
  endtask

  // ---------------- reference K ROM and SHA-256 datapath (ROM_LAT=1) -------
  logic [31:0]  k_out;
  logic [31:0]  blk [16];
  logic [31:0]  ww [64];
  logic [255:0] hp;
  logic [255:0] st;

  always @(posedge clk) k_out <= KT[bus1.k_addr];

  function automatic logic [31:0] ror(logic [31:0] x, int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sched(int t, logic sel);
    logic [31:0] a, b;
    if (!sel) return blk[t % 16];
    a = ror(ww[(t-2)&63], 17) ^ ror(ww[(t-2)&63], 19) ^ (ww[(t-2)&63] >> 10);
    b = ror(ww[(t-15)&63], 7) ^ ror(ww[(t-15)&63], 18) ^ (ww[(t-15)&63] >> 3);
    return a + ww[(t-7)&63] + b + ww[(t-16)&63];
  endfunction

  function automatic logic [255:0] sha_round(logic [255:0] s, logic [31:0] k, logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic logic [255:0] add8(logic [255:0] x, logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus1.init_h) hp <= IV;
    if (bus1.load_ab) st <= hp;
    if (bus1.rnd_en) begin
      ww[bus1.rnd_idx] <= sched(int'(bus1.rnd_idx), bus1.w_sel);
      st <= sha_round(st, k_out, sched(int'(bus1.rnd_idx), bus1.w_sel));
    end
    if (bus1.upd_h) hp <= add8(hp, st);
  end

  // ---------------- scoreboard --------------------------------------------
  typedef struct {int c; int idx;} rnd_ev_t;
  typedef struct {int c; logic [255:0] dig;} dig_ev_t;
  rnd_ev_t rq[$];
  dig_ev_t dq[$];
  int      lq[$];
  int      uq[$];

  // Called while blk_valid is driven in the WAIT_BLK cycle (handshake cycle 0).
  task automatic push_block(bit last, logic [255:0] dig);
    lq.push_back(cyc + 1);
    for (int t = 0; t < ROUNDS; t++) rq.push_back('{cyc + 2 + LAT1 + t, t});
    uq.push_back(cyc + ROUNDS + LAT1 + 2);
    if (last) dq.push_back('{cyc + ROUNDS + LAT1 + 3, dig});
  endtask

  always @(negedge clk) begin
    rnd_ev_t re;
    dig_ev_t de;
    int      c;
    if (bus1.rnd_en) begin
      if (rq.size() == 0) fail_ev("rnd_en");
      else begin
        re = rq.pop_front();
        chk("rnd_cyc", cyc, re.c);
        chk("rnd_idx", bus1.rnd_idx, re.idx);
        chk("w_sel", bus1.w_sel, (re.idx >= 16));
        chk("k_out", k_out, KT[re.idx]);
      end
    end
    if (bus1.w_sel && !bus1.rnd_en) fail_ev("w_sel_without_rnd_en");
    if (bus1.load_ab) begin
      if (lq.size() == 0) fail_ev("load_ab");
      else begin c = lq.pop_front(); chk("load_cyc", cyc, c); end
    end
    if (bus1.upd_h) begin
      if (uq.size() == 0) fail_ev("upd_h");
      else begin c = uq.pop_front(); chk("upd_cyc", cyc, c); end
    end
    if (bus1.digest_valid) begin
      if (dq.size() == 0) fail_ev("digest_valid");
      else begin
        de = dq.pop_front();
        chk("digest_cyc", cyc, de.c);
        chk("digest", hp, de.dig);
      end
    end
    if (bus1.init_h || bus1.load_ab || bus1.upd_h || bus1.digest_valid)
      chk("pulse_onehot", $countones({bus1.init_h, bus1.load_ab, bus1.upd_h, bus1.digest_valid}), 1);
  end

  // ---------------- helpers -----------------------------------------------
  function automatic logic [19:0] outs1();
    return {bus1.blk_ready, bus1.k_addr, bus1.rnd_en, bus1.rnd_idx, bus1.w_sel,
            bus1.init_h, bus1.load_ab, bus1.upd_h, bus1.busy, bus1.digest_valid};
  endfunction

  function automatic logic [19:0] outs2();
    return {bus2.blk_ready, bus2.k_addr, bus2.rnd_en, bus2.rnd_idx, bus2.w_sel,
            bus2.init_h, bus2.load_ab, bus2.upd_h, bus2.busy, bus2.digest_valid};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_blk(int which);
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    case (which)
      0: begin
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
      end
      1: begin
        for (int i = 0; i < 14; i++)
          blk[i] = {8'(97 + i), 8'(98 + i), 8'(99 + i), 8'(100 + i)};
        blk[14] = 32'h80000000;
      end
      default: blk[15] = 32'h000001c0;
    endcase
  endtask

  task automatic wait_ready1();
    int n = 0;
    while (!bus1.blk_ready && n < 300) begin tick(); n++; end
    chk("wait_ready", bus1.blk_ready, 1'b1);
  endtask

  task automatic wait_idle1();
    int n = 0;
    while (bus1.busy && n < 300) begin tick(); n++; end
    chk("wait_idle", bus1.busy, 1'b0);
  endtask

  task automatic start1();
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
  endtask

  task automatic send_block1(int which, bit last, logic [255:0] dig);
    set_blk(which);
    bus1.blk_valid = 1'b1;
    bus1.blk_last  = last;
    push_block(last, dig);
    tick();
    bus1.blk_valid = 1'b0;
    bus1.blk_last  = 1'b0;
  endtask

  // ---------------- stimulus ----------------------------------------------
  typedef struct {
    bit          st;
    bit          bv;
    bit          bl;
    bit          hs;
    logic [10:0] exp;   // {busy, init_h, blk_ready, load_ab, rnd_en, k_addr}
  } vec_t;

  vec_t tv [8];

  initial begin
    tv[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 11'b0_0_0_0_0_000000};
    tv[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 11'b1_1_0_0_0_000000};
    tv[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 11'b1_0_1_0_0_000000};
    tv[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 11'b1_0_1_0_0_000000};
    tv[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 11'b1_0_0_1_0_000000};
    tv[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 11'b1_0_0_0_0_000000};
    tv[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 11'b1_0_0_0_1_000001};
    tv[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 11'b1_0_0_0_1_000010};

    bus1.start = 1'b1; bus1.blk_valid = 1'b0; bus1.blk_last = 1'b0;
    bus2.start = 1'b1; bus2.blk_valid = 1'b0; bus2.blk_last = 1'b0;
    set_blk(0);
    reset = 1'b0;

    // Reset held with start asserted: everything stays zero.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("reset_out1_%0d", i), outs1(), 20'h0);
      chk($sformatf("reset_out2_%0d", i), outs2(), 20'h0);
    end
    bus1.start = 1'b0;
    bus2.start = 1'b0;
    reset = 1'b1;

    // Table-driven entry into a single "abc" block, then let it finish.
    for (int i = 0; i < 8; i++) begin
      bus1.start     = tv[i].st;
      bus1.blk_valid = tv[i].bv;
      bus1.blk_last  = tv[i].bl;
      if (tv[i].hs) begin
        set_blk(0);
        push_block(tv[i].bl, DIG_ABC);
      end
      tick();
      chk($sformatf("vec%0d", i),
          {bus1.busy, bus1.init_h, bus1.blk_ready, bus1.load_ab, bus1.rnd_en, bus1.k_addr}, tv[i].exp);
    end
    bus1.start = 1'b0; bus1.blk_valid = 1'b0; bus1.blk_last = 1'b0;
    wait_idle1();
    chk("abc_queues_empty", rq.size() + dq.size() + uq.size() + lq.size(), 0);

    // Two-block message with a stall between blocks and start pulses while busy.
    start1();
    wait_ready1();
    send_block1(1, 1'b0, '0);
    repeat (20) tick();
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    wait_ready1();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("stall_ready_%0d", i), {bus1.blk_ready, bus1.busy, bus1.load_ab}, 3'b110);
    end
    send_block1(2, 1'b1, DIG_2BLK);
    wait_idle1();
    chk("two_blk_queues_empty", rq.size() + dq.size() + uq.size() + lq.size(), 0);

    // Reset in the middle of the rounds.
    start1();
    wait_ready1();
    send_block1(0, 1'b1, DIG_ABC);
    begin
      int n = 0;
      while (bus1.k_addr != 6'd30 && n < 200) begin tick(); n++; end
    end
    chk("reached_k30", bus1.k_addr, 6'd30);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    rq.delete(); dq.delete(); uq.delete(); lq.delete();
    chk("after_mid_reset", outs1(), 20'h0);
    repeat (80) tick();
    chk("idle_after_abort", outs1(), 20'h0);
    start1();
    wait_ready1();
    send_block1(0, 1'b1, DIG_ABC);
    wait_idle1();
    chk("restart_queues_empty", rq.size() + dq.size() + uq.size() + lq.size(), 0);

    // ROM_LAT=2 instance, cycle-by-cycle expectations relative to the handshake.
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    begin
      int n = 0;
      while (!bus2.blk_ready && n < 20) begin tick(); n++; end
    end
    chk("lat2_ready", bus2.blk_ready, 1'b1);
    begin
      int          h;
      int          rel;
      logic [5:0]  ek, ei;
      logic        en, ws;
      h = cyc;
      bus2.blk_valid = 1'b1;
      bus2.blk_last  = 1'b1;
      for (int i = 1; i <= 75; i++) begin
        tick();
        bus2.blk_valid = 1'b0;
        bus2.blk_last  = 1'b0;
        rel = cyc - h;
        ek = (rel >= 2 && rel <= 65) ? 6'(rel - 2) : 6'd0;
        en = (rel >= 4 && rel <= 67);
        ei = en ? 6'(rel - 4) : 6'd0;
        ws = en && (rel - 4 >= 16);
        chk($sformatf("lat2_rel%0d", rel), outs2(),
            {1'b0, ek, en, ei, ws, 1'b0, (rel == 1), (rel == 68), (rel <= 69), (rel == 69)});
        bus2.start     = (rel >= 10 && rel <= 12) || rel == 40 || rel == 66;
        bus2.blk_valid = (rel >= 20 && rel <= 25);
      end
      bus2.start = 1'b0;
      bus2.blk_valid = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish before 500us");
    $fatal(1, "timeout");
  end

endmodule
